mem_arbiter: RTL and testbench

Shares the single unified memory port of the `eightbit` core between instruction fetch (IF) and load/store (LS). The memory has synchronous reads: it samples `addr`, `we` and write data on a clock edge and returns read data one cycle later. The arbiter picks one requester per cycle, drives the memory port and routes the read-return pulse back to the owner. It sits between the Fetch/ICache and Writeback/LSU logic and the external memory interface.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the unified memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Owner of a memory access: nobody, instruction fetch, or load/store.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    // Width of the consecutive-LS-win counter used in fixed-priority mode.
    localparam int STARVE_CNT_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the IF request port, the LS request port and the external
//            memory port that meet at the arbiter.
//            slave  : the arbiter's view
//            master : the view of the surrounding logic (requesters + memory)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int M_WIDTH = 32
);
    // Instruction-fetch requester.
    logic               if_req;
    logic [M_WIDTH-1:0] if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [M_WIDTH-1:0] if_rdata;

    // Load/store requester.
    logic               ls_req;
    logic               ls_we;
    logic [M_WIDTH-1:0] ls_addr;
    logic [M_WIDTH-1:0] ls_wdata;
    logic               ls_gnt;
    logic               ls_rvalid;
    logic [M_WIDTH-1:0] ls_rdata;

    // External synchronous-read memory.
    logic [M_WIDTH-1:0] mem_addr;
    logic               mem_we;
    logic [M_WIDTH-1:0] mem_wdata;
    logic [M_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Purely combinational winner selection between IF and LS.
//            MEM_ARB_RR_EN defined   : contested cycle goes to whoever did not
//                                      win last (last_win input).
//            MEM_ARB_RR_EN undefined : LS wins contests unless the starve flag
//                                      says IF has waited long enough.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic   if_req,
    input  wire logic   ls_req,
`ifdef MEM_ARB_RR_EN
    input  wire owner_t last_win,
`else
    input  wire logic   starve,
`endif
    output logic        pick_if,
    output logic        pick_ls
);

    // Uncontested requests win outright; contests go to the mode's policy.
    always_comb begin
        pick_if = if_req;
        pick_ls = ls_req;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
            pick_if = (last_win != OWN_IF);
`else
            pick_if = starve;
`endif
            pick_ls = !pick_if;
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one synchronous-read memory port between instruction fetch
//            and load/store. Grants are combinational, read data returns one
//            cycle after the grant and is steered by a registered owner tag.
//            Optional macro MEM_ARB_RR_EN selects round-robin arbitration;
//            otherwise LS has fixed priority with an IF starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int M_WIDTH    = 32,
    parameter int STARVE_LIM = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,   // synchronous, active low
    mem_arbiter_if.slave  bus
);

    logic   w_pick_if;
    logic   w_pick_ls;
    logic   w_if_gnt;
    logic   w_ls_gnt;
    owner_t r_rd_owner;
    owner_t w_rd_owner_nxt;

`ifdef MEM_ARB_RR_EN
    owner_t r_last_win;

    mem_arb_pick u_pick (
        .if_req   (bus.if_req),
        .ls_req   (bus.ls_req),
        .last_win (r_last_win),
        .pick_if  (w_pick_if),
        .pick_ls  (w_pick_ls)
    );

    // Remember the most recent winner; reset to LS so IF takes the first contest.
    always_ff @(posedge clk) begin
        if (!rst)
            r_last_win <= OWN_LS;
        else if (w_if_gnt)
            r_last_win <= OWN_IF;
        else if (w_ls_gnt)
            r_last_win <= OWN_LS;
    end
`else
    localparam logic [STARVE_CNT_W-1:0] c_starve_lim = STARVE_CNT_W'(STARVE_LIM);

    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    w_starve;

    assign w_starve = (r_starve_cnt == c_starve_lim);

    mem_arb_pick u_pick (
        .if_req  (bus.if_req),
        .ls_req  (bus.ls_req),
        .starve  (w_starve),
        .pick_if (w_pick_if),
        .pick_ls (w_pick_ls)
    );

    // Count LS wins over a waiting IF; any IF grant or idle IF clears it.
    // While IF waits, an LS grant is always a contested win.
    always_ff @(posedge clk) begin
        if (!rst)
            r_starve_cnt <= '0;
        else if (w_if_gnt || !bus.if_req)
            r_starve_cnt <= '0;
        else if (w_ls_gnt)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end
`endif

    // No grant may escape while reset is held.
    assign w_if_gnt = rst & w_pick_if;
    assign w_ls_gnt = rst & w_pick_ls;

    // Decide who owns next cycle's read return; writes return nothing.
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_if_gnt)
            w_rd_owner_nxt = OWN_IF;
        else if (w_ls_gnt && !bus.ls_we)
            w_rd_owner_nxt = OWN_LS;
    end

    // Owner tag register; reset drops any in-flight return.
    always_ff @(posedge clk) begin
        if (!rst)
            r_rd_owner <= OWN_NONE;
        else
            r_rd_owner <= w_rd_owner_nxt;
    end

    // Steer the winner's request onto the memory port, idle to zero.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (w_if_gnt) begin
            bus.mem_addr = bus.if_addr;
        end else if (w_ls_gnt) begin
            bus.mem_addr  = bus.ls_addr;
            bus.mem_we    = bus.ls_we;
            bus.mem_wdata = bus.ls_wdata;
        end
    end

    // Grants, return strobes (masked during reset) and shared read data.
    always_comb begin
        bus.if_gnt    = w_if_gnt;
        bus.ls_gnt    = w_ls_gnt;
        bus.if_rvalid = rst & (r_rd_owner == OWN_IF);
        bus.ls_rvalid = rst & (r_rd_owner == OWN_LS);
        bus.if_rdata  = bus.mem_rdata;
        bus.ls_rdata  = bus.mem_rdata;
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a read-first
//            synchronous memory model. Honours MEM_ARB_RR_EN for expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_w = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [c_w-1:0] r_mem [0:63];

    mem_arbiter_if #(.M_WIDTH(c_w)) bus ();

    mem_arbiter #(.M_WIDTH(c_w), .STARVE_LIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous memory: same-edge read sees the old word.
    always @(posedge clk) begin
        if (bus.mem_we)
            r_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        bus.mem_rdata <= r_mem[bus.mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [c_w-1:0] got, input logic [c_w-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Both requesting continuously; check grant pattern and the return owner.
    task automatic contest(input int n);
        logic prev_if;
        logic exp_if;
        prev_if = 1'b0;
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_if = (i % 2 == 0);
`else
            exp_if = (i % 5 == 4);
`endif
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h20;
            bus.ls_req  = 1'b1;
            bus.ls_we   = 1'b0;
            bus.ls_addr = 32'h24;
            #1;
            chk($sformatf("contest_if_gnt[%0d]", i), {31'b0, bus.if_gnt}, {31'b0, exp_if});
            chk($sformatf("contest_ls_gnt[%0d]", i), {31'b0, bus.ls_gnt}, {31'b0, !exp_if});
            if (i > 0) begin
                chk($sformatf("contest_if_rv[%0d]", i), {31'b0, bus.if_rvalid}, {31'b0, prev_if});
                chk($sformatf("contest_ls_rv[%0d]", i), {31'b0, bus.ls_rvalid}, {31'b0, !prev_if});
            end
            prev_if = exp_if;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++)
            r_mem[i] = 32'hA500_0000 + i;
        r_mem[0] = 32'h1111_0000;
        r_mem[1] = 32'h2222_0004;
        r_mem[2] = 32'h3333_0008;
        r_mem[4] = 32'hDEAD_BEEF;
        bus.mem_rdata = '0;
        rst = 1'b0;
        idle_inputs();

        // Reset state while both request.
        @(negedge clk);
        @(negedge clk);
        bus.if_req   = 1'b1;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h44;
        bus.ls_wdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
        chk("rst_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);

        // Single IF read at 0x10.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1;
        chk("ifrd_gnt", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd2);
        chk("ifrd_mem_addr", bus.mem_addr, 32'h10);
        chk("ifrd_mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("ifrd_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd2);
        chk("ifrd_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("ifrd_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);

        // LS write 0x12345678 to 0xE0, then read it back.
        @(negedge clk);
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'hE0;
        bus.ls_wdata = 32'h1234_5678;
        #1;
        chk("lswr_gnt", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd1);
        chk("lswr_mem_we", {31'b0, bus.mem_we}, 32'd1);
        chk("lswr_mem_addr", bus.mem_addr, 32'hE0);
        chk("lswr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        @(negedge clk);
        chk("lswr_no_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        bus.ls_we    = 1'b0;
        bus.ls_wdata = 32'h0;
        #1;
        chk("lsrd_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        chk("lsrd_mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("lsrd_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd1);
        chk("lsrd_rdata", bus.ls_rdata, 32'h1234_5678);
        #1;
        chk("idle_mem_addr", bus.mem_addr, 32'd0);

        // Back-to-back IF reads, one return per cycle with no bubbles.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk($sformatf("b2b_rvalid[%0d]", i), {31'b0, bus.if_rvalid}, 32'd1);
                chk($sformatf("b2b_rdata[%0d]", i), bus.if_rdata, r_mem[i-1]);
            end
            if (i < 3) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'(i * 4);
                #1;
                chk($sformatf("b2b_gnt[%0d]", i), {31'b0, bus.if_gnt}, 32'd1);
                @(negedge clk);
            end
        end
        idle_inputs();

        // Continuous contention from reset arbitration state.
        apply_reset();
        contest(10);

        // Reset in the cycle after an LS read grant drops the return.
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h30;
        #1;
        chk("mid_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h34;
        #1;
        chk("mid_rst_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        chk("mid_rst_gnt", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rel_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
`ifdef MEM_ARB_RR_EN
        chk("mid_rel_first", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd2);
`else
        chk("mid_rel_first", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd1);
`endif
        @(negedge clk);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
